// File: rtl/alu_cmd_sequencer_if.sv
// Host-side bundle of the ALU command sequencer: command push port and
// result return port, both valid/ready.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [2:0] res_op;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_op
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_op
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command front end for the ALU control unit: queues host commands, issues
// one-cycle load/compute strobes, follows actualstate to completion and returns results.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int IDLE_TO = 255,
  parameter int BUSY_TO = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_cmd_sequencer_if.slave host,
  output logic               load,
  output logic               compute,
  output logic [2:0]         op,
  output logic [7:0]         data_out,
  input  logic [4:0]         actualstate,
  input  logic [7:0]         result_in,
  output logic               busy,
  output logic               err,
  input  logic               err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] BUSY_LAST = 8'(BUSY_TO - 1);
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TO - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE, RESULT} state_t;

  state_t        state;
  state_t        state_next;

  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;

  logic          kind;
  logic [7:0]    wait_cnt;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          timeout;

  logic          res_valid_q;
  logic [7:0]    res_data_q;
  logic [2:0]    res_op_q;
  logic          res_free;
  logic          res_take_new;
  logic          res_take_hold;
  logic          hold_take;
  logic [7:0]    hold_data;
  logic [2:0]    hold_op;

  assign fifo_empty     = (count == '0);
  assign fifo_full      = (count == CW'(DEPTH));
  assign push           = host.cmd_valid && !fifo_full;
  assign host.cmd_ready = !fifo_full;

  assign host.res_valid = res_valid_q;
  assign host.res_data  = res_data_q;
  assign host.res_op    = res_op_q;
  assign res_free       = !res_valid_q || host.res_ready;

  assign busy = (state != IDLE) || !fifo_empty;

  // Entry layout is {kind, op, data}; storage needs no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {host.cmd_load, host.cmd_op, host.cmd_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kind     <= 1'b0;
      op       <= 3'd0;
      data_out <= 8'd0;
    end else if (pop) begin
      {kind, op, data_out} <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A finished compute goes straight to the result register when it is free;
  // RESULT is only visited when the previous result is still unconsumed.
  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    load          = 1'b0;
    compute       = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    timeout       = 1'b0;
    res_take_new  = 1'b0;
    res_take_hold = 1'b0;
    hold_take     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        load       = kind;
        compute    = !kind;
        cnt_clr    = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (actualstate != 5'd0) begin
          cnt_clr    = 1'b1;
          state_next = WAIT_IDLE;
        end else if (wait_cnt == BUSY_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (actualstate == 5'd0) begin
          if (kind) begin
            state_next = IDLE;
          end else if (res_free) begin
            res_take_new = 1'b1;
            state_next   = IDLE;
          end else begin
            hold_take  = 1'b1;
            state_next = RESULT;
          end
        end else if (wait_cnt == IDLE_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESULT: begin
        if (res_free) begin
          res_take_hold = 1'b1;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
    end else if (cnt_clr) begin
      wait_cnt <= 8'd0;
    end else if (cnt_inc) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Set has priority so a timeout coinciding with err_clr is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data <= 8'd0;
      hold_op   <= 3'd0;
    end else if (hold_take) begin
      hold_data <= result_in;
      hold_op   <= op;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= 8'd0;
      res_op_q    <= 3'd0;
    end else if (res_take_new) begin
      res_valid_q <= 1'b1;
      res_data_q  <= result_in;
      res_op_q    <= op;
    end else if (res_take_hold) begin
      res_valid_q <= 1'b1;
      res_data_q  <= hold_data;
      res_op_q    <= hold_op;
    end else if (res_valid_q && host.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural control unit/datapath
// model, directed timing/boundary scenarios and a randomized command stream.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load;
  logic       compute;
  logic [2:0] op;
  logic [7:0] data_out;
  logic [4:0] actualstate;
  logic [7:0] result_in;
  logic       busy;
  logic       err;
  logic       err_clr;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(.DEPTH(4), .IDLE_TO(255), .BUSY_TO(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (bus),
    .load        (load),
    .compute     (compute),
    .op          (op),
    .data_out    (data_out),
    .actualstate (actualstate),
    .result_in   (result_in),
    .busy        (busy),
    .err         (err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_issue[$];
  logic [10:0] exp_res[$];
  logic [7:0]  m_acc;

  // cu_mode: 0 = normal, 1 = never leaves S0, 2 = stuck busy until mode returns to 0
  int          cu_mode;
  int          cu_lat_max;
  int          cu_cnt;
  logic [7:0]  cu_acc;
  logic [7:0]  cu_pend;

  function automatic logic [7:0] alu(input logic [2:0] o, input logic [7:0] a);
    case (o)
      3'd0:    return a + 8'd1;
      3'd1:    return a - 8'd1;
      3'd2:    return a ^ 8'hA5;
      3'd3:    return ~a;
      3'd4:    return {a[6:0], 1'b0};
      3'd5:    return {1'b0, a[7:1]};
      3'd6:    return {a[3:0], a[7:4]};
      default: return a + 8'h10;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string detail);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Control unit + datapath: accumulator loaded by load, result = alu(op, acc) on compute.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      actualstate <= 5'd0;
      result_in   <= 8'd0;
      cu_acc      <= 8'd0;
      cu_pend     <= 8'd0;
      cu_cnt      <= 0;
    end else if (actualstate == 5'd0) begin
      if ((load || compute) && cu_mode != 1) begin
        actualstate <= (cu_mode == 2) ? 5'd3 : 5'($urandom_range(1, 20));
        cu_cnt      <= $urandom_range(1, cu_lat_max);
        result_in   <= 8'($urandom);
        if (load) cu_acc <= data_out;
        else      cu_pend <= alu(op, cu_acc);
      end
    end else if (cu_mode != 2) begin
      if (cu_cnt <= 1) begin
        actualstate <= 5'd0;
        result_in   <= cu_pend;
      end else begin
        cu_cnt <= cu_cnt - 1;
      end
    end
  end

  task automatic apply_stimulus(input bit ld, input logic [2:0] o, input logic [7:0] d,
                                input bit completes);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_op    = o;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && n < 600) begin
      step();
      n++;
    end
    if (!bus.cmd_ready) begin
      fail_now("push_wait", "cmd_ready never rose within 600 cycles");
    end else begin
      exp_issue.push_back({ld, o, d});
      if (ld) m_acc = d;
      else if (completes) exp_res.push_back({o, alu(o, m_acc)});
      step();
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || actualstate != 5'd0) && n < limit) begin
      step();
      n++;
    end
    if (busy || actualstate != 5'd0) fail_now("wait_idle", "sequencer still busy at cycle limit");
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check_output({tag, "_load"}, load, 0);
    check_output({tag, "_compute"}, compute, 0);
    check_output({tag, "_op"}, op, 0);
    check_output({tag, "_data_out"}, data_out, 0);
    check_output({tag, "_res_valid"}, bus.res_valid, 0);
    check_output({tag, "_res_data"}, bus.res_data, 0);
    check_output({tag, "_res_op"}, bus.res_op, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_err"}, err, 0);
  endtask

  task automatic clear_model();
    exp_issue.delete();
    exp_res.delete();
    m_acc = 8'd0;
  endtask

  // Strobe monitor: every accepted command must be issued once, in order, as a 1-cycle strobe.
  bit          prev_strobe;
  logic [11:0] iss_e;
  always @(negedge clk) begin
    if (!rst) begin
      prev_strobe = 1'b0;
    end else begin
      if (load || compute) begin
        check_output("strobe_exclusive", load && compute, 0);
        check_output("strobe_one_cycle", prev_strobe, 0);
        if (exp_issue.size() == 0) begin
          fail_now("unexpected_strobe", "strobe with no queued command");
        end else begin
          iss_e = exp_issue.pop_front();
          check_output("issue_kind", load, iss_e[11]);
          check_output("issue_op", op, iss_e[10:8]);
          check_output("issue_data", data_out, iss_e[7:0]);
        end
      end
      prev_strobe = load || compute;
    end
  end

  // Result monitor: compares consumed results against the reference queue.
  bit          hold_prev;
  logic [7:0]  prev_data;
  logic [2:0]  prev_op;
  logic [10:0] res_e;
  always @(negedge clk) begin
    if (!rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && bus.res_valid) begin
        check_output("res_stable_data", bus.res_data, prev_data);
        check_output("res_stable_op", bus.res_op, prev_op);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_res.size() == 0) begin
          fail_now("unexpected_result", "result with no expected compute");
        end else begin
          res_e = exp_res.pop_front();
          check_output("result_data", bus.res_data, res_e[7:0]);
          check_output("result_op", bus.res_op, res_e[10:8]);
        end
      end
      hold_prev = bus.res_valid && !bus.res_ready;
      prev_data = bus.res_data;
      prev_op   = bus.res_op;
    end
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 8'd0;
    bus.res_ready = 1'b0;
    err_clr       = 1'b0;
    cu_mode       = 0;
    cu_lat_max    = 1;
    clear_model();

    repeat (3) step();
    check_reset_values("reset");
    rst = 1'b1;
    repeat (2) step();

    // Compute round trip: acc=0xFF, op2 -> 0x5A
    apply_stimulus(1'b1, 3'd0, 8'hFF, 1'b1);
    wait_idle(50);
    apply_stimulus(1'b0, 3'd2, 8'h00, 1'b1);
    check_output("rt_e0_compute", compute, 0);
    step();
    check_output("rt_e1_compute", compute, 1);
    check_output("rt_e1_op", op, 2);
    step();
    check_output("rt_e2_compute", compute, 0);
    step();
    check_output("rt_e3_res_valid", bus.res_valid, 0);
    step();
    check_output("rt_e4_res_valid", bus.res_valid, 1);
    check_output("rt_e4_res_data", bus.res_data, 8'h5A);
    check_output("rt_e4_res_op", bus.res_op, 2);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check_output("rt_res_cleared", bus.res_valid, 0);

    // Result backpressure: ~0xFF = 0x00 (op3), 0xFF>>1 = 0x7F (op5)
    apply_stimulus(1'b0, 3'd3, 8'h00, 1'b1);
    apply_stimulus(1'b0, 3'd5, 8'h00, 1'b1);
    repeat (15) step();
    check_output("bp_first_valid", bus.res_valid, 1);
    check_output("bp_first_data", bus.res_data, 8'h00);
    check_output("bp_first_op", bus.res_op, 3);
    check_output("bp_busy_in_result", busy, 1);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check_output("bp_second_valid", bus.res_valid, 1);
    check_output("bp_second_data", bus.res_data, 8'h7F);
    check_output("bp_second_op", bus.res_op, 5);
    check_output("bp_busy_released", busy, 0);
    bus.res_ready = 1'b1;
    step();
    check_output("bp_second_consumed", bus.res_valid, 0);

    // Full FIFO with the control unit stalled on an in-flight load
    cu_mode = 2;
    apply_stimulus(1'b1, 3'd0, 8'h11, 1'b1);
    repeat (4) step();
    apply_stimulus(1'b1, 3'd6, 8'h3C, 1'b1);
    apply_stimulus(1'b0, 3'd0, 8'h01, 1'b1);
    apply_stimulus(1'b0, 3'd1, 8'h02, 1'b1);
    apply_stimulus(1'b0, 3'd4, 8'h03, 1'b1);
    check_output("full_cmd_ready", bus.cmd_ready, 0);
    check_output("full_busy", busy, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'd7;
    bus.cmd_data  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("full_fifth_held", bus.cmd_ready, 0);
    end
    cu_mode = 0;
    apply_stimulus(1'b0, 3'd7, 8'h99, 1'b1);
    wait_idle(200);

    // Busy timeout: control unit ignores the strobe
    cu_mode = 1;
    apply_stimulus(1'b0, 3'd3, 8'h00, 1'b0);
    repeat (5) step();
    check_output("busy_to_before", err, 0);
    step();
    check_output("busy_to_err_set", err, 1);
    cu_mode = 0;
    apply_stimulus(1'b0, 3'd2, 8'h00, 1'b1);
    wait_idle(50);
    check_output("busy_to_err_sticky", err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_output("err_clr_clears", err, 0);

    // Idle timeout with err_clr held: the set must win on the timeout edge
    cu_mode = 2;
    err_clr = 1'b1;
    apply_stimulus(1'b0, 3'd1, 8'h00, 1'b0);
    repeat (257) step();
    check_output("idle_to_before", err, 0);
    step();
    check_output("idle_to_err_set_wins", err, 1);
    check_output("idle_to_no_result", bus.res_valid, 0);
    step();
    check_output("idle_to_clr_after", err, 0);
    err_clr = 1'b0;
    cu_mode = 0;
    wait_idle(50);

    // Asynchronous reset with one op in WAIT_IDLE and three queued
    cu_mode = 2;
    bus.res_ready = 1'b0;
    apply_stimulus(1'b0, 3'd0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 3'd1, 8'h00, 1'b1);
    apply_stimulus(1'b1, 3'd2, 8'h44, 1'b1);
    apply_stimulus(1'b0, 3'd3, 8'h00, 1'b1);
    step();
    check_output("pre_reset_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("midreset");
    clear_model();
    cu_mode = 0;
    step();
    rst = 1'b1;
    repeat (10) step();
    check_output("post_reset_idle", busy, 0);

    // Reset during ISSUE drops the strobe without a clock edge
    apply_stimulus(1'b0, 3'd5, 8'h00, 1'b1);
    step();
    check_output("issue_strobe_high", compute, 1);
    #2;
    rst = 1'b0;
    #1;
    check_output("reset_drops_strobe", compute, 0);
    clear_model();
    step();
    rst = 1'b1;
    repeat (2) step();

    // Randomized stream with random latency and result backpressure
    cu_lat_max = 3;
    for (int i = 0; i < 120; i++) begin
      bus.res_ready = 1'($urandom_range(0, 1));
      if (bus.cmd_ready && ($urandom_range(0, 2) != 0)) begin
        apply_stimulus(($urandom_range(0, 2) == 0), 3'($urandom), 8'($urandom), 1'b1);
      end else begin
        step();
      end
    end
    bus.res_ready = 1'b1;
    begin
      int n = 0;
      while ((exp_res.size() != 0 || exp_issue.size() != 0 || busy) && n < 3000) begin
        step();
        n++;
      end
    end
    check_output("drain_results", exp_res.size(), 0);
    check_output("drain_issues", exp_issue.size(), 0);
    check_output("random_no_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-issuing front end for the ALU control unit: buffers host commands in a small FIFO and drives the control unit's `load`/`compute`/`op` inputs with single-cycle strobes. It tracks the control unit's `actualstate` to detect the start and completion of each operation, then returns compute results to the host through a valid/ready port. It sits between the host/testbench and the control-unit plus datapath pair, and is the initiator side of the control unit's command interface.

## Interface
- `DEPTH`, 4: command FIFO depth; power of two, at least 2.
- `IDLE_TO`, 255: maximum cycles to wait for the control unit to return to S0 (8-bit counter).
- `BUSY_TO`, 4: maximum cycles to wait for the control unit to leave S0 after a strobe.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_load`  in  1  1 = load command, 0 = compute command.
- `cmd_op`  in  3  ALU opcode for compute commands (0–7).
- `cmd_data`  in  8  operand driven on `data_out` during a load.
- `load`  out  1  load strobe to the control unit.
- `compute`  out  1  compute strobe to the control unit.
- `op`  out  3  opcode to the control unit.
- `data_out`  out  8  operand bus to the datapath.
- `actualstate`  in  5  control unit state; 0 = S0 (idle).
- `result_in`  in  8  datapath result.
- `res_valid`  out  1  result register full.
- `res_ready`  in  1  host consumes the result.
- `res_data`  out  8  captured result.
- `res_op`  out  3  opcode that produced `res_data`.
- `busy`  out  1  state is not IDLE, or the FIFO is non-empty.
- `err`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `err`.

## Operation
- **FIFO.** A push occurs when `cmd_valid && cmd_ready`. Each entry is {load, op, data}.
  - `cmd_ready` = not full. There is no pass-through when full.
  - A push and a pop in the same cycle are both allowed and leave the count unchanged.
- **FSM states:** IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE, RESULT.
- **IDLE.** If the FIFO is non-empty: pop the head into the issue registers (`op`, `data_out`, kind) and go to ISSUE. Otherwise stay in IDLE.
- **ISSUE.** Exactly one cycle with `load` = kind, or `compute` = !kind. Then go to WAIT_BUSY with the busy counter at 0.
  - `load` and `compute` are never high together.
  - Outside ISSUE, both strobes are 0.
- **WAIT_BUSY.**
  - If `actualstate` != 0: go to WAIT_IDLE with the idle counter at 0.
  - Otherwise increment the counter. When it reaches `BUSY_TO`: set `err`, drop the command, go to IDLE.
- **WAIT_IDLE.**
  - If `actualstate` == 0: for a compute, capture `result_in` → `res_data` and `op` → `res_op`, and go to RESULT. For a load, go to IDLE.
  - Otherwise increment the counter. When it reaches `IDLE_TO`: set `err`, go to IDLE, no result.
- **RESULT.**
  - If `res_valid` == 0: set `res_valid` and go to IDLE.
  - If `res_valid` == 1 (previous result not yet consumed): hold the captured value internally and stall until the host consumes it, then set `res_valid` and go to IDLE.
  - `res_data` never changes while `res_valid` = 1.
- **Result handshake.** `res_valid` clears on `res_valid && res_ready`.
- **Error flag.**
  - `err` clears when `err_clr` = 1.
  - A timeout in the same cycle as `err_clr` leaves `err` = 1 (set wins).
- **Stability.** `op` and `data_out` hold their values from ISSUE until the next pop.

## Timing
- **Reset values.** While `rst` = 0:
  - FIFO emptied; state IDLE.
  - `cmd_ready` = 1.
  - `load` = `compute` = 0; `op` = 0; `data_out` = 0.
  - `res_valid` = 0; `res_data` = 0; `res_op` = 0.
  - `busy` = 0; `err` = 0.
- **Mid-operation reset.** An asynchronous reset during any state aborts immediately: strobes drop without waiting for a clock, and FIFO contents are lost.
- **Single compute, empty sequencer.**
  - Command accepted at edge E0.
  - Pop at E1; strobe high from E1 to E2.
  - Control unit leaves S0 at E2 and returns at E3.
  - Result captured at E4; `res_valid` = 1 after E4.
- **Throughput.** Back-to-back commands issue one strobe per 4 cycles, with no result backpressure.
- **Load commands.** Same timing as compute; back to IDLE at E4 with no result.

## Test plan
- **Reset.** Assert `rst` = 0 mid-WAIT_IDLE with 3 queued commands → all outputs immediately at reset values; no strobe after release until new pushes.
- **Compute round trip.** Push compute op=2 with a model control unit (one-cycle state, `result_in` = 0x5A) → `compute` high exactly 1 cycle with `op` = 2; `res_valid` after E4 with `res_data` = 0x5A, `res_op` = 2.
- **Full FIFO.** Push 5 commands back-to-back with the strobe path stalled → `cmd_ready` = 0 after the 4th accept; 5th held; all 4 issued in order load, op0, op1, op4.
- **Result backpressure.** Two computes with `res_ready` = 0 → first result held unchanged; second held in RESULT; after `res_ready` pulses, second result appears, no loss.
- **Busy timeout.** Control unit never leaves S0 → `err` = 1 after the 4th WAIT_BUSY cycle; next command still issues; `err_clr` returns `err` to 0.
- **Idle timeout.** `actualstate` stuck at 3 → `err` set after 255 WAIT_IDLE cycles; `res_valid` stays 0.
